// File: rtl/audio_system_debug_pkg.sv
// Shared types and constants for the Nios II debug-slave sysclk command path.
package audio_system_debug_pkg;

  localparam int CMD_IR_W   = 2;
  localparam int CMD_DATA_W = 38;
  localparam int CMD_W      = CMD_IR_W + CMD_DATA_W;

  localparam logic [CMD_IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [CMD_IR_W-1:0] IR_TRACE     = 2'd1;
  localparam logic [CMD_IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [CMD_IR_W-1:0] IR_TRACECTRL = 2'd3;

  typedef struct packed {
    logic [CMD_IR_W-1:0]   ir;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/audio_system_debug_cmd_sysclk_if.sv
// Valid/ready command stream from the sysclk capture stage to the OCI decoders.
interface audio_system_debug_cmd_sysclk_if
  import audio_system_debug_pkg::*;
#(
  parameter int IR_W   = CMD_IR_W,
  parameter int DATA_W = CMD_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_action;

  modport master (
    output cmd_valid,
    output cmd_ir,
    output cmd_data,
    output cmd_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ir,
    input  cmd_data,
    input  cmd_action,
    output cmd_ready
  );

endinterface

// File: rtl/audio_system_debug_sync_edge.sv
// Level synchroniser with a rise detector that stays disarmed until the
// synchronised level has genuinely been seen low after reset.
module audio_system_debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev;
  logic                   armed;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // fill_q tracks which chain stages hold real post-reset samples, so the
  // reset zeros in sync_q cannot arm the detector on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      fill_q <= '0;
      prev   <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev   <= sync;
      if (fill_q[SYNC_STAGES-1] && !sync) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = sync & ~prev & armed;

endmodule

// File: rtl/audio_system_debug_cmd_sysclk.sv
// Captures TCK-domain update-IR / exit1-DR events into a show-ahead command
// FIFO in the system clock domain.
module audio_system_debug_cmd_sysclk
  import audio_system_debug_pkg::*;
#(
  parameter int DATA_W      = CMD_DATA_W,
  parameter int IR_W        = CMD_IR_W,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACT_BIT     = 34
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_W-1:0]                  sr,
  input  logic [IR_W-1:0]                    ir_in,
  input  logic                               vs_uir_d1,
  input  logic                               vs_e1dr_d1,
  audio_system_debug_cmd_sysclk_if.master    cmd,
  output logic                               ir_update,
  output logic [IR_W-1:0]                    ir_cur,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               overflow,
  input  logic                               overflow_clr
);

  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = IR_W + DATA_W;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic               uir_rise;
  logic               e1dr_rise;
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] head;
  logic [IR_W-1:0]    ir_sel;
  logic               valid;
  logic               full;
  logic               pop;
  logic               accept;
  logic               drop;

  audio_system_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_edge (
    .clk   (clk),
    .reset (reset),
    .din   (vs_uir_d1),
    .rise  (uir_rise)
  );

  audio_system_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_e1dr_edge (
    .clk   (clk),
    .reset (reset),
    .din   (vs_e1dr_d1),
    .rise  (e1dr_rise)
  );

  // A push into a full FIFO is still accepted when the head leaves the same cycle.
  always_comb begin
    valid  = (fifo_level != '0);
    full   = (fifo_level == FULL_LVL);
    pop    = valid & cmd.cmd_ready;
    accept = e1dr_rise & (~full | pop);
    drop   = e1dr_rise & full & ~pop;
    ir_sel = uir_rise ? ir_in : ir_cur;
    head   = valid ? mem[rd_ptr] : '0;
  end

  assign cmd.cmd_valid  = valid;
  assign cmd.cmd_ir     = head[ENTRY_W-1:DATA_W];
  assign cmd.cmd_data   = head[DATA_W-1:0];
  assign cmd.cmd_action = head[ACT_BIT];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {ir_sel, sr};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      ir_cur     <= '0;
      ir_update  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
      ir_update <= uir_rise;
      if (uir_rise) begin
        ir_cur <= ir_in;
      end
    end
  end

endmodule

// File: tb/tb_audio_system_debug_cmd_sysclk.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// sample-history / queue reference model of the sysclk command stage.
module tb_audio_system_debug_cmd_sysclk;
  import audio_system_debug_pkg::*;

  localparam int DATA_W      = 38;
  localparam int IR_W        = 2;
  localparam int SYNC_STAGES = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int ACT_BIT     = 34;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] sr;
  logic [IR_W-1:0]   ir_in;
  logic              vs_uir_d1;
  logic              vs_e1dr_d1;
  logic              ir_update;
  logic [IR_W-1:0]   ir_cur;
  logic [2:0]        fifo_level;
  logic              overflow;
  logic              overflow_clr;

  audio_system_debug_cmd_sysclk_if #(.IR_W(IR_W), .DATA_W(DATA_W)) cmd_if ();

  audio_system_debug_cmd_sysclk #(
    .DATA_W      (DATA_W),
    .IR_W        (IR_W),
    .SYNC_STAGES (SYNC_STAGES),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ACT_BIT     (ACT_BIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sr           (sr),
    .ir_in        (ir_in),
    .vs_uir_d1    (vs_uir_d1),
    .vs_e1dr_d1   (vs_e1dr_d1),
    .cmd          (cmd_if),
    .ir_update    (ir_update),
    .ir_cur       (ir_cur),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: post-reset input samples, command queue, sticky flag, IR state.
  bit              uir_hist[$];
  bit              e1dr_hist[$];
  cmd_t            m_fifo[$];
  logic [IR_W-1:0] m_ir_cur = '0;
  bit              m_ir_update = 1'b0;
  bit              m_overflow = 1'b0;

  // An event is acted on SYNC_STAGES edges after the first high sample that
  // follows a low sample, both taken after reset.
  task automatic model_edge();
    int   mu;
    int   me;
    bit   u;
    bit   e;
    bit   pop;
    bit   full;
    cmd_t c;
    if (reset) begin
      uir_hist.delete();
      e1dr_hist.delete();
      m_fifo.delete();
      m_ir_cur    = '0;
      m_ir_update = 1'b0;
      m_overflow  = 1'b0;
      return;
    end
    mu = uir_hist.size();
    me = e1dr_hist.size();
    u = (mu >= SYNC_STAGES + 1) && uir_hist[mu-SYNC_STAGES] && !uir_hist[mu-SYNC_STAGES-1];
    e = (me >= SYNC_STAGES + 1) && e1dr_hist[me-SYNC_STAGES] && !e1dr_hist[me-SYNC_STAGES-1];
    uir_hist.push_back(vs_uir_d1);
    e1dr_hist.push_back(vs_e1dr_d1);
    if (uir_hist.size() > 8) uir_hist.delete(0);
    if (e1dr_hist.size() > 8) e1dr_hist.delete(0);
    pop  = (m_fifo.size() != 0) && cmd_if.cmd_ready;
    full = (m_fifo.size() == FIFO_DEPTH);
    c.ir   = u ? ir_in : m_ir_cur;
    c.data = sr;
    if (pop) m_fifo.delete(0);
    if (e && full && !pop) m_overflow = 1'b1;
    else if (overflow_clr) m_overflow = 1'b0;
    if (e && !(full && !pop)) m_fifo.push_back(c);
    m_ir_update = u;
    if (u) m_ir_cur = ir_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic e1dr_pulse(input logic [DATA_W-1:0] v);
    sr = v;
    vs_e1dr_d1 = 1'b1;
    repeat (2) tick();
    vs_e1dr_d1 = 1'b0;
    repeat (3) tick();
  endtask

  task automatic uir_pulse(input logic [IR_W-1:0] ir);
    ir_in = ir;
    vs_uir_d1 = 1'b1;
    repeat (2) tick();
    vs_uir_d1 = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    bit early;
    reset = 1'b1;
    vs_e1dr_d1 = 1'b1;
    repeat (3) tick();
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_level got %0d exp 0", fifo_level); end
    vectors++; if (cmd_if.cmd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid got %0b exp 0", cmd_if.cmd_valid); end
    vectors++; if (cmd_if.cmd_data !== '0 || cmd_if.cmd_ir !== '0 || cmd_if.cmd_action !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_cmd got ir %0h data %0h act %0b exp all 0", cmd_if.cmd_ir, cmd_if.cmd_data, cmd_if.cmd_action); end
    vectors++; if (ir_cur !== '0 || ir_update !== 1'b0 || overflow !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_flags got ir_cur %0h upd %0b ovf %0b exp 0", ir_cur, ir_update, overflow); end
    reset = 1'b0;
    early = 1'b0;
    repeat (6) begin tick(); if (cmd_if.cmd_valid !== 1'b0) early = 1'b1; end
    vectors++; if (early) begin miscompares++; $display("[TB] FAIL held_high_push got push exp none"); end
    vs_e1dr_d1 = 1'b0;
    repeat (3) tick();
    sr = 38'h2_0000_0005;
    vs_e1dr_d1 = 1'b1;
    repeat (2) tick();
    vectors++; if (cmd_if.cmd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_early got valid %0b exp 0", cmd_if.cmd_valid); end
    tick();
    vectors++; if (cmd_if.cmd_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL latency_3rd got valid %0b exp 1", cmd_if.cmd_valid); end
    vectors++; if (cmd_if.cmd_data !== 38'h2_0000_0005) begin miscompares++; $display("[TB] FAIL first_data got %0h exp 2000000005", cmd_if.cmd_data); end
    vectors++; if (cmd_if.cmd_action !== 1'b0 || cmd_if.cmd_ir !== 2'd0) begin
      miscompares++; $display("[TB] FAIL first_act_ir got act %0b ir %0h exp 0 0", cmd_if.cmd_action, cmd_if.cmd_ir); end
    vs_e1dr_d1 = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    vectors++; if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin
      miscompares++; $display("[TB] FAIL first_pop got valid %0b level %0d exp 0 0", cmd_if.cmd_valid, fifo_level); end
    tick();
  endtask

  task automatic test_ir_update();
    int pulses;
    logic [DATA_W-1:0] v;
    pulses = 0;
    ir_in = IR_BREAK;
    vs_uir_d1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) vs_uir_d1 = 1'b0;
      tick();
      if (ir_update === 1'b1) pulses++;
    end
    vectors++; if (pulses != 1) begin miscompares++; $display("[TB] FAIL ir_update_width got %0d cycles exp 1", pulses); end
    vectors++; if (ir_cur !== IR_BREAK) begin miscompares++; $display("[TB] FAIL ir_cur got %0h exp 2", ir_cur); end
    v = {6'($urandom()), $urandom()};
    v[ACT_BIT] = 1'b1;
    e1dr_pulse(v);
    vectors++; if (cmd_if.cmd_ir !== IR_BREAK || cmd_if.cmd_action !== 1'b1) begin
      miscompares++; $display("[TB] FAIL act_cmd got ir %0h act %0b exp 2 1", cmd_if.cmd_ir, cmd_if.cmd_action); end
    vectors++; if (cmd_if.cmd_data !== v) begin miscompares++; $display("[TB] FAIL act_data got %0h exp %0h", cmd_if.cmd_data, v); end
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
  endtask

  task automatic test_overflow();
    cmd_if.cmd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) e1dr_pulse(DATA_W'(i));
    vectors++; if (fifo_level !== 3'd4) begin miscompares++; $display("[TB] FAIL ovf_level got %0d exp 4", fifo_level); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag got %0b exp 1", overflow); end
    cmd_if.cmd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      vectors++; if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_data !== DATA_W'(i)) begin
        miscompares++; $display("[TB] FAIL drain_order got valid %0b data %0h exp 1 %0h", cmd_if.cmd_valid, cmd_if.cmd_data, i); end
      tick();
    end
    cmd_if.cmd_ready = 1'b0;
    vectors++; if (cmd_if.cmd_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_empty got valid %0b exp 0", cmd_if.cmd_valid); end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_clear got %0b exp 0", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = {6'($urandom()), $urandom()};
      exp_q.push_back(v);
      e1dr_pulse(v);
    end
    v = {6'($urandom()), $urandom()};
    sr = v;
    vs_e1dr_d1 = 1'b1;
    repeat (2) tick();
    vs_e1dr_d1 = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    exp_q.delete(0);
    exp_q.push_back(v);
    vectors++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      miscompares++; $display("[TB] FAIL full_pushpop got level %0d ovf %0b exp 4 0", fifo_level, overflow); end
    repeat (2) tick();
    vectors++; if (cmd_if.cmd_data !== exp_q[0]) begin
      miscompares++; $display("[TB] FAIL stall_hold got %0h exp %0h", cmd_if.cmd_data, exp_q[0]); end
    cmd_if.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (cmd_if.cmd_data !== exp_q[i]) begin
        miscompares++; $display("[TB] FAIL b2b_order idx %0d got %0h exp %0h", i, cmd_if.cmd_data, exp_q[i]); end
      tick();
    end
    cmd_if.cmd_ready = 1'b0;
  endtask

  task automatic test_same_cycle();
    uir_pulse(IR_TRACE);
    ir_in = IR_TRACECTRL;
    sr = {6'($urandom()), $urandom()};
    vs_uir_d1 = 1'b1;
    vs_e1dr_d1 = 1'b1;
    repeat (2) tick();
    vs_uir_d1 = 1'b0;
    vs_e1dr_d1 = 1'b0;
    tick();
    vectors++; if (cmd_if.cmd_ir !== IR_TRACECTRL || fifo_level !== 3'd1) begin
      miscompares++; $display("[TB] FAIL same_cycle_ir got ir %0h level %0d exp 3 1", cmd_if.cmd_ir, fifo_level); end
    vectors++; if (ir_cur !== IR_TRACECTRL || ir_update !== 1'b1) begin
      miscompares++; $display("[TB] FAIL same_cycle_cur got %0h upd %0b exp 3 1", ir_cur, ir_update); end
    repeat (2) tick();
    for (int i = 0; i < 3; i++) e1dr_pulse({6'($urandom()), $urandom()});
    sr = {6'($urandom()), $urandom()};
    vs_e1dr_d1 = 1'b1;
    repeat (2) tick();
    vs_e1dr_d1 = 1'b0;
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    vectors++; if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
      miscompares++; $display("[TB] FAIL drop_beats_clr got ovf %0b level %0d exp 1 4", overflow, fifo_level); end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    repeat (4) tick();
    cmd_if.cmd_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_flush();
    bit late;
    for (int i = 0; i < 3; i++) e1dr_pulse({6'($urandom()), $urandom()});
    vs_e1dr_d1 = 1'b1;
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    vectors++; if (fifo_level !== 3'd0 || cmd_if.cmd_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL flush got level %0d valid %0b exp 0 0", fifo_level, cmd_if.cmd_valid); end
    late = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) vs_e1dr_d1 = 1'b0;
      tick();
      if (cmd_if.cmd_valid !== 1'b0) late = 1'b1;
    end
    vectors++; if (late) begin miscompares++; $display("[TB] FAIL late_push got push exp none"); end
  endtask

  task automatic test_random();
    cmd_t exp_head;
    bit   exp_valid;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reset        = ($urandom_range(0, 299) == 0);
      ir_in        = IR_W'($urandom());
      sr           = {6'($urandom()), $urandom()};
      if ($urandom_range(0, 5) == 0) vs_uir_d1 = ~vs_uir_d1;
      if ($urandom_range(0, 2) == 0) vs_e1dr_d1 = ~vs_e1dr_d1;
      cmd_if.cmd_ready = ((cyc / 100) % 2 == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      overflow_clr = ($urandom_range(0, 9) == 0);
      tick();
      exp_valid = (m_fifo.size() != 0);
      exp_head  = exp_valid ? m_fifo[0] : '0;
      vectors++; if (cmd_if.cmd_valid !== exp_valid) begin
        miscompares++; $display("[TB] FAIL rand_valid cyc %0d got %0b exp %0b", cyc, cmd_if.cmd_valid, exp_valid); end
      vectors++; if (cmd_if.cmd_data !== exp_head.data || cmd_if.cmd_ir !== exp_head.ir) begin
        miscompares++; $display("[TB] FAIL rand_head cyc %0d got %0h/%0h exp %0h/%0h", cyc, cmd_if.cmd_ir, cmd_if.cmd_data, exp_head.ir, exp_head.data); end
      vectors++; if (cmd_if.cmd_action !== exp_head.data[ACT_BIT]) begin
        miscompares++; $display("[TB] FAIL rand_action cyc %0d got %0b exp %0b", cyc, cmd_if.cmd_action, exp_head.data[ACT_BIT]); end
      vectors++; if (fifo_level !== 3'(m_fifo.size())) begin
        miscompares++; $display("[TB] FAIL rand_level cyc %0d got %0d exp %0d", cyc, fifo_level, m_fifo.size()); end
      vectors++; if (overflow !== m_overflow) begin
        miscompares++; $display("[TB] FAIL rand_overflow cyc %0d got %0b exp %0b", cyc, overflow, m_overflow); end
      vectors++; if (ir_update !== m_ir_update || ir_cur !== m_ir_cur) begin
        miscompares++; $display("[TB] FAIL rand_ir cyc %0d got %0b/%0h exp %0b/%0h", cyc, ir_update, ir_cur, m_ir_update, m_ir_cur); end
    end
    reset = 1'b0;
    overflow_clr = 1'b0;
    cmd_if.cmd_ready = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    sr               = '0;
    ir_in            = '0;
    vs_uir_d1        = 1'b0;
    vs_e1dr_d1       = 1'b0;
    overflow_clr     = 1'b0;
    cmd_if.cmd_ready = 1'b0;
    test_reset();
    test_ir_update();
    test_overflow();
    test_back_to_back();
    test_same_cycle();
    test_reset_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/audio_system_debug_cmd_sysclk.md
Name: audio_system_debug_cmd_sysclk

Overview:
System-clock-domain command capture stage for the Nios II debug slave, successor to the fixed-width sysclk decoder.
- Synchronises the TCK-domain update-IR and exit1-DR indications.
- Latches the JTAG shift register together with the current instruction as one command.
- Buffers commands in a parametrised show-ahead FIFO behind a valid/ready handshake, so back-to-back debugger transactions survive a stalled OCI consumer.
- Sits between the virtual-JTAG TCK logic and the OCI break/ocimem/trace decoders.

Parameters:
DATA_W, 38, shift-register (sr) width in bits.
IR_W, 2, virtual-JTAG instruction width.
SYNC_STAGES, 2, synchroniser depth per async input; legal range >= 2.
FIFO_DEPTH, 4, command buffer entries; power of 2, >= 2.
ACT_BIT, 34, index within sr of the action/no-action qualifier bit.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
sr  in  DATA_W  TCK-domain shift register; quasi-static and stable while vs_e1dr_d1 is high.
ir_in  in  IR_W  TCK-domain instruction register; stable while vs_uir_d1 is high.
vs_uir_d1  in  1  async level; high after update-IR.
vs_e1dr_d1  in  1  async level; high after exit1-DR.
cmd_valid  out  1  FIFO head is valid.
cmd_ready  in  1  consumer accepts the head.
cmd_ir  out  IR_W  instruction of the head command.
cmd_data  out  DATA_W  sr snapshot of the head command.
cmd_action  out  1  cmd_data[ACT_BIT].
ir_update  out  1  one-cycle pulse when a new instruction is latched.
ir_cur  out  IR_W  last latched instruction.
fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries.
overflow  out  1  sticky flag: a command was dropped.
overflow_clr  in  1  clears overflow.

Behaviour:
- Clock and reset: single clock domain (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - all synchroniser flops, edge-prev flops and arm flags = 0;
  - FIFO empty, so fifo_level = 0 and cmd_valid = 0;
  - cmd_ir, cmd_data, cmd_action, ir_update, ir_cur and overflow = 0.
  - Reset asserted mid-operation flushes the FIFO and discards in-flight edges.
- Synchronisation: each async input passes through a SYNC_STAGES flop chain, then a rise detector.
  - rise = sync & ~prev & armed.
  - armed sets on the first cycle the synchronised level is seen 0 after reset. An input held high through reset therefore produces no event until it has been seen low.
- Latency: if the input is first sampled high at clk edge k, the rise is acted on at edge k+SYNC_STAGES.
  - cmd_valid or ir_update is visible in the cycle after that edge.
  - With SYNC_STAGES = 2 this is the 3rd sampling edge.
- uir rise: ir_cur <= ir_in; ir_update = 1 for exactly one cycle.
- e1dr rise: push {ir_sel, sr}.
  - ir_sel = ir_in if a uir rise occurs in the same cycle, else ir_cur.
  - sr is sampled in the same cycle as the rise.
- FIFO: show-ahead. cmd_* reflect the head; cmd_valid = level != 0.
  - Pop when cmd_valid & cmd_ready.
  - cmd_* hold stable while cmd_valid & ~cmd_ready.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level saturates at FIFO_DEPTH and never wraps.
- Full:
  - push with no pop: command dropped, FIFO unchanged, overflow <= 1.
  - push with pop in the same cycle: accepted, level unchanged, no overflow.
- Empty: cmd_ready ignored; no pointer movement.
- overflow: sticky. overflow_clr clears it. A same-cycle new drop wins (overflow stays 1).
- cmd_action is combinational from the head entry. It is 0 whenever cmd_valid = 0 (head data masked to 0).

Decomposition:
- Package audio_system_debug_pkg:
  - IR code constants: IR_OCIMEM = 0, IR_TRACE = 1, IR_BREAK = 2, IR_TRACECTRL = 3;
  - localparam CMD_W = IR_W + DATA_W;
  - command struct type {ir, data}.
- Sub-module audio_system_debug_sync_edge: parametrised by SYNC_STAGES; implements the sync chain, prev flop, arm flag and rise output. Instantiated twice.
- FIFO storage and pointers are inline.

Test Plan:
1. Reset with vs_e1dr_d1 held high, then release reset -> no push. Drop the input low for 3 cycles, then raise it with sr = 38'h2_0000_0005 and ir_cur = 0 -> cmd_valid after the 3rd sampling edge, cmd_data = 38'h2_0000_0005, cmd_action = 0.
2. Pulse vs_uir_d1 with ir_in = 2'b10 -> ir_update high for one cycle, ir_cur = 2. Then pulse e1dr with sr[34] = 1 -> cmd_ir = 2, cmd_action = 1.
3. Hold cmd_ready = 0 and issue 5 e1dr pulses with sr = 1..5 (FIFO_DEPTH = 4) -> fifo_level = 4, overflow = 1. Then drain -> data pops in order 1, 2, 3, 4.
4. FIFO full, cmd_ready = 1 on the same cycle as a push rise -> level stays 4, overflow stays 0, new entry appears last.
5. Same-cycle uir and e1dr rises with ir_in = 3 and ir_cur = 1 -> pushed cmd_ir = 3. Assert overflow_clr together with a drop -> overflow remains 1.
6. Assert reset with 3 entries queued and a rise in flight -> after release, fifo_level = 0, cmd_valid = 0, no late push.
